jt053246_objbuf: RTL and testbench

Sprite-table front end for the k053246/7 and k053244/5 sprite pipeline. It holds the CPU-visible register file and performs the vertical-blank DMA copy of the external object RAM into an internal double-width object buffer. The buffer is read by the sprite scan engine, one even word and one odd word per object slot. It sits between the CPU/object-RAM bus and the sprite line scanner.

---
 rtl/jt053246_objbuf.sv | 145 ++++++++++++++
 tb/tb_jt053246_objbuf.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/jt053246_objbuf.sv
// Sprite-table front end: CPU register file plus vblank DMA of object RAM into a double-width object buffer.
// Optional JT053246_FLICKER_EN: frame counter driving a flicker bit that toggles every 8 frames.
module jt053246_objbuf (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl2_cen,
  input  logic        k44_en,
  input  logic        cs,
  input  logic        cpu_we,
  input  logic [3:1]  cpu_addr,
  input  logic [15:0] cpu_dout,
  input  logic [1:0]  cpu_dsn,
  input  logic        hs,
  input  logic        vs,
  output logic [13:1] dma_addr,
  input  logic [15:0] dma_data,
  output logic        dma_bsy,
  input  logic [9:0]  scan_addr,
  output logic [15:0] scan_even,
  output logic [15:0] scan_odd,
  output logic [7:0]  cfg,
  output logic [9:0]  xoffset,
  output logic [9:0]  yoffset,
  output logic [20:0] rmrd_addr,
  output logic        flicker,
  input  logic [7:0]  st_addr,
  output logic [7:0]  st_dout
);

  typedef enum logic [1:0] {IDLE, ARMED, COPY} dma_st_t;

  logic [7:0]  regs [8];
  logic        reg_we;
  logic        vs_l, vs_rise;
  logic        k44_trig, k44_trig_l, dma_trig;
  dma_st_t     st, st_nx;
  logic [10:0] dma_cnt;
  logic        dma_we, dma_last;
  logic [15:0] buf_even [1024];
  logic [15:0] buf_odd  [1024];
  logic        unused_hs;

  assign unused_hs = hs;

  // The k44 chip decodes one more address bit; writes above its register window are dropped
  assign reg_we = cs & cpu_we & ~(k44_en & cpu_addr[3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
    end else if (reg_we) begin
      if (!cpu_dsn[1]) regs[{cpu_addr[2:1], 1'b0}] <= cpu_dout[15:8];
      if (!cpu_dsn[0]) regs[{cpu_addr[2:1], 1'b1}] <= cpu_dout[7:0];
    end
  end

  assign xoffset   = {regs[0][1:0], regs[1]};
  assign yoffset   = {regs[2][1:0], regs[3]};
  assign cfg       = regs[5];
  assign rmrd_addr = {regs[6][4:0], regs[7], regs[4]};
  assign st_dout   = (st_addr[7:3] == 5'd0) ? regs[st_addr[2:0]] : 8'd0;

  assign vs_rise  = vs & ~vs_l;
  assign k44_trig = cs & (cpu_addr == 3'd3);
  assign dma_trig = k44_en ? (k44_trig & ~k44_trig_l) : (vs_rise & cfg[4]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_l       <= 1'b0;
      k44_trig_l <= 1'b0;
    end else begin
      vs_l       <= vs;
      k44_trig_l <= k44_trig;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // Triggers only register in IDLE, so edges seen during a copy are discarded
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (dma_trig) st_nx = ARMED;
      ARMED:   if (pxl2_cen) st_nx = COPY;
      COPY:    if (pxl2_cen && dma_last) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    dma_bsy = (st == COPY);
  end

  // The word presented on dma_addr is captured and written on the following pxl2_cen
  assign dma_we   = pxl2_cen & dma_bsy;
  assign dma_last = dma_cnt == (k44_en ? 11'h3ff : 11'h7ff);
  assign dma_addr = {2'b00, dma_cnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_cnt <= 11'd0;
    end else if (!dma_bsy) begin
      dma_cnt <= 11'd0;
    end else if (pxl2_cen) begin
      dma_cnt <= dma_last ? 11'd0 : dma_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (dma_we) begin
      if (dma_cnt[0]) buf_odd[dma_cnt[10:1]]  <= dma_data;
      else            buf_even[dma_cnt[10:1]] <= dma_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_even <= 16'd0;
      scan_odd  <= 16'd0;
    end else begin
      scan_even <= buf_even[scan_addr];
      scan_odd  <= buf_odd[scan_addr];
    end
  end

`ifdef JT053246_FLICKER_EN
  logic [2:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 3'd0;
      flicker   <= 1'b0;
    end else if (vs_rise) begin
      frame_cnt <= frame_cnt + 3'd1;
      if (&frame_cnt) flicker <= ~flicker;
    end
  end
`else
  assign flicker = 1'b0;
`endif

endmodule

// File: tb/tb_jt053246_objbuf.sv
// Directed bench for jt053246_objbuf: register file, DMA timing/triggers, buffer contents, reset abort.
module tb_jt053246_objbuf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl2_cen = 1'b0;
  logic        k44_en = 1'b0;
  logic        cs = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:1]  cpu_addr = 3'd0;
  logic [15:0] cpu_dout = 16'd0;
  logic [1:0]  cpu_dsn = 2'b11;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [13:1] dma_addr;
  logic [15:0] dma_data;
  logic        dma_bsy;
  logic [9:0]  scan_addr = 10'd0;
  logic [15:0] scan_even, scan_odd;
  logic [7:0]  cfg;
  logic [9:0]  xoffset, yoffset;
  logic [20:0] rmrd_addr;
  logic        flicker;
  logic [7:0]  st_addr = 8'd0;
  logic [7:0]  st_dout;
  logic [15:0] data_mask = 16'd0;
  int          err_cnt = 0;
  int          chk_cnt = 0;

  jt053246_objbuf dut (
    .clk(clk), .rst(rst), .pxl2_cen(pxl2_cen), .k44_en(k44_en),
    .cs(cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_dsn(cpu_dsn),
    .hs(hs), .vs(vs), .dma_addr(dma_addr), .dma_data(dma_data), .dma_bsy(dma_bsy),
    .scan_addr(scan_addr), .scan_even(scan_even), .scan_odd(scan_odd),
    .cfg(cfg), .xoffset(xoffset), .yoffset(yoffset), .rmrd_addr(rmrd_addr),
    .flicker(flicker), .st_addr(st_addr), .st_dout(st_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    pxl2_cen = ~pxl2_cen;
  end

  // Object RAM model: each word holds its own index, optionally tagged by data_mask
  assign dma_data = {3'b000, dma_addr} ^ data_mask;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [3:1] a, input logic [15:0] d, input logic [1:0] dsn);
    @(negedge clk);
    cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_dout = d; cpu_dsn = dsn;
    @(negedge clk);
    cs = 1'b0; cpu_we = 1'b0; cpu_dsn = 2'b11;
  endtask

  task automatic scan_chk(input string tag, input logic [9:0] a, input logic [15:0] ev, input logic [15:0] od);
    @(negedge clk);
    scan_addr = a;
    @(negedge clk);
    check_val({tag, "_even"}, scan_even, ev);
    check_val({tag, "_odd"}, scan_odd, od);
  endtask

  // Counts pxl2_cen edges at which dma_bsy is high before or after the edge
  task automatic run_dma(input int limit, input bit extra_vs, output int cen_cnt, output int max_addr);
    bit prev_b, prev_c, started;
    cen_cnt = 0; max_addr = 0; started = 1'b0;
    prev_b = dma_bsy; prev_c = pxl2_cen;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (i == 0) cs = 1'b0;
      if (extra_vs && i == 100) vs = 1'b0;
      if (extra_vs && i == 200) vs = 1'b1;
      if (prev_c && (prev_b || dma_bsy)) cen_cnt++;
      if (dma_bsy) started = 1'b1;
      if (int'(dma_addr) > max_addr) max_addr = int'(dma_addr);
      if (started && !dma_bsy) break;
      prev_b = dma_bsy; prev_c = pxl2_cen;
    end
  endtask

  initial begin
    int n, ma;
    repeat (3) @(negedge clk);
    check_val("rst_cfg", cfg, 0);
    check_val("rst_xoff", xoffset, 0);
    check_val("rst_yoff", yoffset, 0);
    check_val("rst_rmrd", rmrd_addr, 0);
    check_val("rst_bsy", dma_bsy, 0);
    check_val("rst_dma_addr", dma_addr, 0);
    check_val("rst_flicker", flicker, 0);
    check_val("rst_scan_even", scan_even, 0);
    check_val("rst_scan_odd", scan_odd, 0);
    rst = 1'b0;

    cpu_write(3'd0, 16'h0123, 2'b00);
    check_val("xoff_0123", xoffset, 10'h123);
    check_val("cfg_after_w0", cfg, 0);
    check_val("bsy_after_w0", dma_bsy, 0);
    st_addr = 8'd0; #1;
    check_val("st_r0", st_dout, 8'h01);

    cpu_write(3'd2, 16'h5510, 2'b10);
    check_val("cfg_low_lane", cfg, 8'h10);
    st_addr = 8'd4; #1;
    check_val("st_r4_untouched", st_dout, 8'h00);
    st_addr = 8'd5; #1;
    check_val("st_r5", st_dout, 8'h10);
    st_addr = 8'h0d; #1;
    check_val("st_out_of_range", st_dout, 8'h00);

    cpu_write(3'd1, 16'h0345, 2'b00);
    check_val("yoff_0345", yoffset, 10'h345);
    cpu_write(3'd3, 16'h1f56, 2'b00);
    cpu_write(3'd2, 16'h7800, 2'b01);
    check_val("rmrd", rmrd_addr, 21'h1f5678);
    check_val("cfg_after_upper", cfg, 8'h10);

    // k053246 copy on vs rising edge
    @(negedge clk); vs = 1'b1;
    run_dma(6000, 1'b0, n, ma);
    check_val("dma46_duration", n, 2049);
    check_val("dma46_done", dma_bsy, 0);
    check_val("dma46_max_addr", ma, 32'h7ff);
    check_val("dma46_idle_addr", dma_addr, 0);
    scan_chk("scan05", 10'h005, 16'h000a, 16'h000b);
    scan_chk("scan000", 10'h000, 16'h0000, 16'h0001);
    scan_chk("scan3ff", 10'h3ff, 16'h07fe, 16'h07ff);

    // second vs edge during the copy must not restart it
    @(negedge clk); vs = 1'b0;
    @(negedge clk); vs = 1'b1;
    run_dma(6000, 1'b1, n, ma);
    check_val("dma46_retrig_duration", n, 2049);
    check_val("dma46_retrig_done", dma_bsy, 0);

    // cfg[4]=0 blocks the vs trigger
    cpu_write(3'd2, 16'h0000, 2'b10);
    check_val("cfg_cleared", cfg, 0);
    @(negedge clk); vs = 1'b0;
    @(negedge clk); vs = 1'b1;
    run_dma(40, 1'b0, n, ma);
    check_val("no_dma_cfg0", n, 0);

    // k44 mode: high-bank write ignored, cs trigger copies 1024 words
    k44_en = 1'b1;
    data_mask = 16'ha000;
    cpu_write(3'b100, 16'hffff, 2'b00);
    check_val("k44_hi_write_ignored", xoffset, 10'h123);
    @(negedge clk); cs = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd3;
    run_dma(4000, 1'b0, n, ma);
    check_val("dma44_duration", n, 1025);
    check_val("dma44_max_addr", ma, 32'h3ff);
    check_val("dma44_done", dma_bsy, 0);
    scan_chk("k44_scan05", 10'h005, 16'ha00a, 16'ha00b);
    scan_chk("k44_scan1ff", 10'h1ff, 16'ha3fe, 16'ha3ff);
    scan_chk("k44_scan200", 10'h200, 16'h0400, 16'h0401);

    // reset in the middle of a copy
    data_mask = 16'h5000;
    @(negedge clk); cs = 1'b1; cpu_addr = 3'd3;
    @(negedge clk); cs = 1'b0;
    for (int i = 0; i < 1000 && !(dma_bsy && dma_addr >= 50); i++) @(negedge clk);
    check_val("mid_copy_active", dma_bsy, 1);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check_val("rst_abort_bsy", dma_bsy, 0);
    check_val("rst_abort_addr", dma_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_regs_cfg", cfg, 0);
    check_val("rst_regs_xoff", xoffset, 0);
    repeat (20) @(negedge clk);
    check_val("post_rst_bsy", dma_bsy, 0);
    check_val("post_rst_addr", dma_addr, 0);
    scan_chk("abort_scan000", 10'h000, 16'h5000, 16'h5001);
    scan_chk("abort_scan040", 10'h040, 16'ha080, 16'ha081);
    scan_chk("abort_scan1ff", 10'h1ff, 16'ha3fe, 16'ha3ff);
    check_val("flicker_off", flicker, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
